// File: rtl/regfile_writeback_if.sv
// Bundle of the ALU/LSU result handshakes and register-file write port
// seen by regfile_writeback.
interface regfile_writeback_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [ADDR_W-1:0] lsu_rd;
  logic [DATA_W-1:0] lsu_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [31:0]       pending_mask;

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready, wr_en, wr_addr, wr_data, pending_mask
  );

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready, wr_en, wr_addr, wr_data, pending_mask
  );
endinterface

// File: rtl/regfile_writeback.sv
// Register-file write-port arbiter: ALU results plus a small LSU load FIFO,
// with a pending-destination mask for decode stalls.
module regfile_writeback #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int LSU_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  regfile_writeback_if.slave  bus
);
  localparam int PTR_W = $clog2(LSU_DEPTH);

  logic [ADDR_W-1:0] r_fifo_rd   [LSU_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [LSU_DEPTH];
  logic [PTR_W-1:0]  r_rptr;
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W:0]    r_count;

  logic              r_wr_en;
  logic              r_out_lsu;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_alu_acc;
  logic [31:0]       w_pend;

  assign w_full    = (r_count == (PTR_W+1)'(LSU_DEPTH));
  assign w_push    = bus.lsu_valid && !w_full;
  // A full FIFO always wins so the ALU cannot starve buffered loads.
  assign w_pop     = w_full || (!bus.alu_valid && (r_count != '0));
  assign w_alu_acc = bus.alu_valid && !w_full;

  assign bus.alu_ready    = !w_full;
  assign bus.lsu_ready    = !w_full;
  assign bus.wr_en        = r_wr_en;
  assign bus.wr_addr      = r_wr_addr;
  assign bus.wr_data      = r_wr_data;
  assign bus.pending_mask = w_pend;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= bus.lsu_rd;
      r_fifo_data[r_wptr] <= bus.lsu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_en   <= 1'b0;
      r_out_lsu <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_pop) begin
      r_wr_en   <= (r_fifo_rd[r_rptr] != '0);
      r_out_lsu <= 1'b1;
      r_wr_addr <= r_fifo_rd[r_rptr];
      r_wr_data <= r_fifo_data[r_rptr];
    end else if (w_alu_acc) begin
      r_wr_en   <= (bus.alu_rd != '0);
      r_out_lsu <= 1'b0;
      r_wr_addr <= bus.alu_rd;
      r_wr_data <= bus.alu_data;
    end else begin
      r_wr_en   <= 1'b0;
      r_out_lsu <= 1'b0;
    end
  end

  // Walk occupied slots from the head so wrapped entries are included.
  always_comb begin
    w_pend = '0;
    for (int unsigned i = 0; i < LSU_DEPTH; i++) begin
      if (i < 32'(r_count))
        w_pend[r_fifo_rd[r_rptr + PTR_W'(i)]] = 1'b1;
    end
    if (r_wr_en && r_out_lsu)
      w_pend[r_wr_addr] = 1'b1;
    w_pend[0] = 1'b0;
  end
endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: queue-based reference model,
// randomized handshake traffic, directed scenarios and mid-stream resets.
module tb_regfile_writeback;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 4;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_writeback_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_writeback #(.DATA_W(DW), .ADDR_W(AW), .LSU_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;

  // Reference model state
  ent_t          mq[$];
  ent_t          exp_q[$];
  logic          m_wr = 1'b0;
  logic          m_out_lsu = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;

  // Stimulus sources
  ent_t alu_src[$];
  ent_t lsu_src[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (mq[i]) m[mq[i].rd] = 1'b1;
    if (m_wr && m_out_lsu) m[m_addr] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  // Model: one write-port winner per cycle from FIFO occupancy and ALU request.
  always @(posedge clk) begin
    ent_t e;
    bit   have;
    bit   from_lsu;
    bit   full;
    if (reset) begin
      mq.delete();
      exp_q.delete();
      m_wr = 1'b0;
      m_out_lsu = 1'b0;
      m_addr = '0;
      m_data = '0;
    end else begin
      full = (mq.size() == DEPTH);
      have = 1'b0;
      from_lsu = 1'b0;
      if (full || (!bus.alu_valid && mq.size() > 0)) begin
        e = mq.pop_front();
        have = 1'b1;
        from_lsu = 1'b1;
      end else if (bus.alu_valid) begin
        e.rd = bus.alu_rd;
        e.data = bus.alu_data;
        have = 1'b1;
      end
      if (bus.lsu_valid && !full) begin
        ent_t p;
        p.rd = bus.lsu_rd;
        p.data = bus.lsu_data;
        mq.push_back(p);
      end
      if (have) begin
        m_wr = (e.rd != 0);
        m_out_lsu = from_lsu;
        m_addr = e.rd;
        m_data = e.data;
        if (e.rd != 0) exp_q.push_back(e);
      end else begin
        m_wr = 1'b0;
        m_out_lsu = 1'b0;
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (mon_en) begin
      chk("wr_en", 64'(bus.wr_en), 64'(m_wr));
      chk("alu_ready", 64'(bus.alu_ready), 64'(mq.size() != DEPTH));
      chk("lsu_ready", 64'(bus.lsu_ready), 64'(mq.size() != DEPTH));
      chk("pending_mask", 64'(bus.pending_mask), 64'(model_mask()));
      if (bus.wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'(bus.wr_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 64'(bus.wr_addr), 64'(e.rd));
          chk("wr_data", 64'(bus.wr_data), 64'(e.data));
        end
      end else if (!m_wr) begin
        chk("hold_addr", 64'(bus.wr_addr), 64'(m_addr));
        chk("hold_data", 64'(bus.wr_data), 64'(m_data));
      end
    end
  end

  task automatic set_idle();
    bus.alu_valid = 1'b0;
    bus.alu_rd = '0;
    bus.alu_data = '0;
    bus.lsu_valid = 1'b0;
    bus.lsu_rd = '0;
    bus.lsu_data = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    set_idle();
    alu_src.delete();
    lsu_src.delete();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Offers are held until accepted; new offers appear with the given percentages.
  task automatic drive(input int n, input int ap, input int lp);
    bit a_acc, l_acc, a_hold, l_hold;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      a_acc = bus.alu_valid && bus.alu_ready;
      l_acc = bus.lsu_valid && bus.lsu_ready;
      @(posedge clk); #1;
      a_hold = bus.alu_valid && !a_acc;
      l_hold = bus.lsu_valid && !l_acc;
      if (a_acc && alu_src.size() > 0) void'(alu_src.pop_front());
      if (l_acc && lsu_src.size() > 0) void'(lsu_src.pop_front());
      if (alu_src.size() > 0 && (a_hold || $urandom_range(99) < ap)) begin
        bus.alu_valid = 1'b1;
        bus.alu_rd = alu_src[0].rd;
        bus.alu_data = alu_src[0].data;
      end else begin
        bus.alu_valid = 1'b0;
      end
      if (lsu_src.size() > 0 && (l_hold || $urandom_range(99) < lp)) begin
        bus.lsu_valid = 1'b1;
        bus.lsu_rd = lsu_src[0].rd;
        bus.lsu_data = lsu_src[0].data;
      end else begin
        bus.lsu_valid = 1'b0;
      end
    end
  endtask

  task automatic add_alu(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    ent_t e;
    e.rd = rd;
    e.data = d;
    alu_src.push_back(e);
  endtask

  task automatic add_lsu(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    ent_t e;
    e.rd = rd;
    e.data = d;
    lsu_src.push_back(e);
  endtask

  initial begin
    set_idle();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    reset = 1'b0;

    // ALU burst
    add_alu(5'd1, 32'h11);
    add_alu(5'd2, 32'h22);
    add_alu(5'd3, 32'h33);
    drive(6, 100, 0);

    // x0 discard
    add_alu(5'd0, 32'hDEADBEEF);
    drive(4, 100, 0);

    // LSU fill under continuous ALU pressure
    for (int i = 0; i < 12; i++) add_alu(5'(9 + i), $urandom);
    for (int i = 5; i <= 8; i++) add_lsu(5'(i), 32'h1000 + 32'(i));
    drive(24, 100, 100);

    // Push/pop steady state with wrap: ALU pressure builds count, then LSU alone
    for (int i = 0; i < 2; i++) add_alu(5'(20 + i), $urandom);
    for (int i = 0; i < 10; i++) add_lsu(5'(i + 1), 32'h2000 + 32'(i));
    drive(20, 100, 100);

    // Reset mid-drain
    for (int i = 0; i < 10; i++) add_alu(5'(1 + i), $urandom);
    for (int i = 0; i < 3; i++) add_lsu(5'(12 + i), $urandom);
    drive(5, 100, 100);
    do_reset();
    drive(8, 0, 0);

    // Randomized traffic, with a reset in the middle
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 150; i++) begin
        add_alu(5'($urandom_range(31)), $urandom);
        add_lsu(5'($urandom_range(31)), $urandom);
      end
      drive(200, 40 + 20 * r, 50);
      if (r == 0) do_reset();
    end
    alu_src.delete();
    lsu_src.delete();
    drive(20, 0, 0);

    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side front end for the core's 32×32 register file. It accepts results from the ALU and the load/store unit (LSU) and buffers LSU load results in a small FIFO. It arbitrates the single register-file write port and drives the registered `wr_en/wr_addr/wr_data`. It also publishes a pending-destination mask so decode can stall on registers whose load data has not yet been written back.

## Interface
- `DATA_W`, 32, data width of results and register-file write data
- `ADDR_W`, 5, register address width (32 registers)
- `LSU_DEPTH`, 4, LSU result FIFO entries; power of two, ≥2

- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  reset, synchronous, active-high
- `alu_valid`  in  1  ALU result present this cycle
- `alu_ready`  out  1  ALU result accepted when `alu_valid && alu_ready`
- `alu_rd`  in  ADDR_W  ALU destination register
- `alu_data`  in  DATA_W  ALU result
- `lsu_valid`  in  1  load result present
- `lsu_ready`  out  1  FIFO not full
- `lsu_rd`  in  ADDR_W  load destination register
- `lsu_data`  in  DATA_W  load result
- `wr_en`  out  1  register-file write enable (registered)
- `wr_addr`  out  ADDR_W  register-file write address (registered)
- `wr_data`  out  DATA_W  register-file write data (registered)
- `pending_mask`  out  32  bit i = a load result for register i is buffered or in the output stage

## Operation
- The LSU FIFO is circular with a read pointer, a write pointer and a count of width log2(LSU_DEPTH)+1. Pointers wrap modulo LSU_DEPTH.
- `lsu_ready = (count != LSU_DEPTH)`. There is no push-through when full, even if a pop happens in the same cycle.
- Push: `lsu_valid && lsu_ready` stores {rd, data} at the write pointer.
- `alu_ready = (count != LSU_DEPTH)`.
- Write-port arbitration, one winner per cycle, fixed priority:
  1. FIFO full: FIFO head pops; the ALU is stalled.
  2. Otherwise, if `alu_valid`: the ALU is accepted.
  3. Otherwise, if count > 0: FIFO head pops.
  4. Otherwise: idle.
- The winner's {rd, data} is loaded into the output register next edge. `wr_en` is 1 if rd ≠ 0, else 0. A result targeting x0 is consumed and discarded.
- When idle, `wr_en` = 0 next cycle. `wr_addr`/`wr_data` hold their previous values.
- Simultaneous push and pop (not full) is allowed; count is unchanged.
- Ordering: results are written in acceptance order within each source. There is no ordering guarantee between the ALU and the LSU; the issue logic prevents same-rd hazards using `pending_mask`.
- `pending_mask` is combinational from registered state. It is the OR of one-hot(rd) over all occupied FIFO entries, plus the output register when it holds an LSU-originated write with `wr_en` = 1. Bit 0 is always 0.
- Reset mid-operation discards all buffered entries and any in-flight write. No partial write is issued.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, count=0, both pointers=0, `pending_mask`=0, `lsu_ready`=1, `alu_ready`=1. Ready outputs are 1 in the first cycle after `reset` deasserts.
- ALU latency: accepted in cycle N → `wr_en`=1 in cycle N+1.
- LSU latency, empty FIFO, no ALU traffic: pushed in cycle N → head visible N+1 → `wr_en`=1 in cycle N+2.
- `pending_mask` bit sets in the cycle after the push and clears in the cycle after the corresponding write leaves the output register.
- Throughput: one register-file write per cycle, maximum.

## Test plan
- Reset then ALU burst: `alu_valid`=1 for 3 cycles with rd=1,2,3 and data=0x11,0x22,0x33 → `wr_en`=1 in the next 3 cycles with matching addr/data; `alu_ready` stays 1.
- x0 discard: ALU rd=0, data=0xDEADBEEF accepted → next cycle `wr_en`=0; `pending_mask` stays 0.
- LSU fill under ALU pressure: `alu_valid`=1 continuously while pushing 4 loads (rd=5..8) → `lsu_ready`=0 and `alu_ready`=0 once count=4. The next cycle pops rd=5, and `pending_mask` shows bits 5–8 then drops bit 5 after its write. All four loads drain in order, interleaved with ALU writes as stated by the arbitration rules.
- Simultaneous push/pop with count=2, no ALU: count stays 2 and the FIFO order is preserved across pointer wrap (push 6+ entries total).
- Reset mid-drain: count=3 and `wr_en`=1 when `reset` is asserted for 1 cycle → next cycle `wr_en`=0, `pending_mask`=0, `lsu_ready`=1; no stale entry is ever written afterwards.
